// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the Mini SRC hardwired control sequencer:
//   - opcode and ALU op_sel encodings
//   - FSM state encoding (also exported on state_view for debug)
//   - instruction-class decode used by the sequencer
//   - packed control-word struct driven onto the datapath interface
// -----------------------------------------------------------------------------
package control_pkg;

  localparam int OPW  = 5;  // opcode width, IR[31:27]
  localparam int ALUW = 5;  // op_sel width

  // Opcodes
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU operation selects (R-type instructions pass their opcode straight through)
  localparam logic [ALUW-1:0] ALU_NONE = 5'b00000;
  localparam logic [ALUW-1:0] ALU_ADD  = 5'b00011;
  localparam logic [ALUW-1:0] ALU_AND  = 5'b00101;
  localparam logic [ALUW-1:0] ALU_OR   = 5'b00110;

  // FSM states, 4-bit encoding
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd15
  } state_t;

  // Instruction classes: instructions in one class share an execute sequence
  typedef enum logic [3:0] {
    C_NONE,   // nop and every undefined opcode: no execute cycles
    C_LD,
    C_LDI,
    C_ST,
    C_RTYPE,
    C_IMM,
    C_BR,
    C_JR,
    C_HALT
  } iclass_t;

  // One bit per datapath enable plus the ALU select
  typedef struct packed {
    logic            pc_out;
    logic            mdr_out;
    logic            zlo_out;
    logic            r_out;
    logic            c_out;
    logic            ba_out;
    logic            mar_rd;
    logic            mdr_rd;
    logic            ir_rd;
    logic            pc_rd;
    logic            y_rd;
    logic            zlo_rd;
    logic            r_in;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            inc_pc;
    logic            read;
    logic            write;
    logic            con_in;
    logic [ALUW-1:0] op_sel;
  } ctrl_t;

  function automatic iclass_t decode_class(input logic [OPW-1:0] op);
    iclass_t c;
    case (op)
      OP_LD:   c = C_LD;
      OP_LDI:  c = C_LDI;
      OP_ST:   c = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL:
               c = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:
               c = C_IMM;
      OP_BR:   c = C_BR;
      OP_JR:   c = C_JR;
      OP_HALT: c = C_HALT;
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  // ALU select for the immediate forms; they reuse the R-type ALU codes
  function automatic logic [ALUW-1:0] imm_alu_op(input logic [OPW-1:0] op);
    logic [ALUW-1:0] a;
    case (op)
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
// Signal bundle between the control sequencer and the Mini SRC datapath.
//   datapath -> sequencer : ir, con_ff, mem_ready
//   sequencer -> datapath : bus drive enables, register load enables,
//                           Gra/Grb/Grc, IncPC/Read/Write/CON_in, op_sel
//   status                : run, state_view
// modport master = sequencer side, modport slave = datapath side.
// -----------------------------------------------------------------------------
interface control_sequencer_if;
  import control_pkg::*;

  logic [31:0]     ir;
  logic            con_ff;
  logic            mem_ready;

  logic            PC_out, MDR_out, Zlo_out, R_out, C_out, BAout;
  logic            MAR_rd, MDR_rd, IR_rd, PC_rd, Y_rd, Zlo_rd, Rin;
  logic            Gra, Grb, Grc;
  logic            IncPC, Read, Write, CON_in;
  logic [ALUW-1:0] op_sel;
  logic            run;
  logic [3:0]      state_view;

  modport master (
    input  ir, con_ff, mem_ready,
    output PC_out, MDR_out, Zlo_out, R_out, C_out, BAout,
    output MAR_rd, MDR_rd, IR_rd, PC_rd, Y_rd, Zlo_rd, Rin,
    output Gra, Grb, Grc,
    output IncPC, Read, Write, CON_in,
    output op_sel, run, state_view
  );

  modport slave (
    output ir, con_ff, mem_ready,
    input  PC_out, MDR_out, Zlo_out, R_out, C_out, BAout,
    input  MAR_rd, MDR_rd, IR_rd, PC_rd, Y_rd, Zlo_rd, Rin,
    input  Gra, Grb, Grc,
    input  IncPC, Read, Write, CON_in,
    input  op_sel, run, state_view
  );

endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit for the Mini SRC datapath. Steps through
// fetch (T0..T2) and then the execute sequence selected by IR[31:27],
// stalling in the memory states until mem_ready, and parking in HALT.
// Ports:
//   clk  - system clock, all state changes on posedge
//   clr  - asynchronous active-low reset, forces state RST
//   bus  - control_sequencer_if.master: ir/con_ff/mem_ready in,
//          all datapath control enables, op_sel, run, state_view out
// Outputs are a pure decode of (state, opcode, con_ff); holding the state
// during a memory stall therefore holds every output unchanged, and the
// asynchronous reset clears them in the same cycle clr falls.
// -----------------------------------------------------------------------------
module control_sequencer
  import control_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  state_t          state_reg;
  iclass_t         iclass;
  logic [OPW-1:0]  opcode;
  ctrl_t           ctrl;
  logic            unused_ir;

  assign opcode    = bus.ir[31:27];
  assign iclass    = decode_class(opcode);
  assign unused_ir = ^bus.ir[26:0];

  // ---------------------------------------------------------------------------
  // State register. Any class that has no further execute step returns to T0,
  // so a changed or undefined opcode can never strand the sequencer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= S_RST;
    end else begin
      case (state_reg)
        S_RST: state_reg <= S_T0;
        S_T0:  state_reg <= S_T1;
        S_T1:  if (bus.mem_ready) state_reg <= S_T2;
        S_T2: begin
          case (iclass)
            C_NONE:  state_reg <= S_T0;
            C_HALT:  state_reg <= S_HALT;
            default: state_reg <= S_T3;
          endcase
        end
        S_T3: begin
          if (iclass inside {C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_BR})
            state_reg <= S_T4;
          else
            state_reg <= S_T0;
        end
        S_T4: begin
          if (iclass inside {C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_BR})
            state_reg <= S_T5;
          else
            state_reg <= S_T0;
        end
        S_T5: begin
          if (iclass inside {C_LD, C_ST, C_BR})
            state_reg <= S_T6;
          else
            state_reg <= S_T0;
        end
        S_T6: begin
          case (iclass)
            C_LD:    if (bus.mem_ready) state_reg <= S_T7;  // read stall
            C_ST:    state_reg <= S_T7;
            default: state_reg <= S_T0;
          endcase
        end
        S_T7: begin
          // store holds here until the write is accepted
          if (!(iclass == C_ST && !bus.mem_ready))
            state_reg <= S_T0;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_RST;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Every field defaults to 0; RST and HALT add nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_rd = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.zlo_rd = 1'b1;
      end
      S_T1: begin
        ctrl.zlo_out = 1'b1;
        ctrl.pc_rd   = 1'b1;
        ctrl.read    = 1'b1;
        ctrl.mdr_rd  = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_rd   = 1'b1;
      end
      S_T3: begin
        case (iclass)
          C_LD, C_LDI, C_ST: begin
            // base register plus BAout so R0 reads as zero for the address
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.y_rd   = 1'b1;
          end
          C_RTYPE, C_IMM: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_rd  = 1'b1;
          end
          C_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.con_in = 1'b1;
          end
          C_JR: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_rd = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_LD, C_LDI, C_ST: begin
            ctrl.c_out  = 1'b1;
            ctrl.zlo_rd = 1'b1;
            ctrl.op_sel = ALU_ADD;
          end
          C_RTYPE: begin
            ctrl.grc    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.zlo_rd = 1'b1;
            ctrl.op_sel = opcode;  // R-type opcodes double as ALU selects
          end
          C_IMM: begin
            ctrl.c_out  = 1'b1;
            ctrl.zlo_rd = 1'b1;
            ctrl.op_sel = imm_alu_op(opcode);
          end
          C_BR: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_rd   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_LDI, C_RTYPE, C_IMM: begin
            ctrl.zlo_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          C_LD, C_ST: begin
            ctrl.zlo_out = 1'b1;
            ctrl.mar_rd  = 1'b1;
          end
          C_BR: begin
            ctrl.c_out  = 1'b1;
            ctrl.zlo_rd = 1'b1;
            ctrl.op_sel = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_rd = 1'b1;
          end
          C_ST: begin
            // store data goes to MDR from the register file, not memory
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_rd = 1'b1;
          end
          C_BR: begin
            ctrl.zlo_out = bus.con_ff;
            ctrl.pc_rd   = bus.con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          C_ST:    ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.PC_out     = ctrl.pc_out;
  assign bus.MDR_out    = ctrl.mdr_out;
  assign bus.Zlo_out    = ctrl.zlo_out;
  assign bus.R_out      = ctrl.r_out;
  assign bus.C_out      = ctrl.c_out;
  assign bus.BAout      = ctrl.ba_out;
  assign bus.MAR_rd     = ctrl.mar_rd;
  assign bus.MDR_rd     = ctrl.mdr_rd;
  assign bus.IR_rd      = ctrl.ir_rd;
  assign bus.PC_rd      = ctrl.pc_rd;
  assign bus.Y_rd       = ctrl.y_rd;
  assign bus.Zlo_rd     = ctrl.zlo_rd;
  assign bus.Rin        = ctrl.r_in;
  assign bus.Gra        = ctrl.gra;
  assign bus.Grb        = ctrl.grb;
  assign bus.Grc        = ctrl.grc;
  assign bus.IncPC      = ctrl.inc_pc;
  assign bus.Read       = ctrl.read;
  assign bus.Write      = ctrl.write;
  assign bus.CON_in     = ctrl.con_in;
  assign bus.op_sel     = ctrl.op_sel;
  assign bus.run        = (state_reg != S_RST) && (state_reg != S_HALT);
  assign bus.state_view = state_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// For every instruction issued, the stimulus process expands a per-instruction
// table of (state, enables, op_sel) steps, adds mem_ready stall cycles, and
// pushes one expectation per clock into a queue. A separate monitor pops one
// expectation at each falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_control_sequencer;
  import control_pkg::*;

  // enable bit masks, bit order matches got_en below
  localparam logic [19:0] PC_OUT  = 20'h00001;
  localparam logic [19:0] MDR_OUT = 20'h00002;
  localparam logic [19:0] ZLO_OUT = 20'h00004;
  localparam logic [19:0] R_OUT   = 20'h00008;
  localparam logic [19:0] C_OUT   = 20'h00010;
  localparam logic [19:0] BAOUT   = 20'h00020;
  localparam logic [19:0] MAR_RD  = 20'h00040;
  localparam logic [19:0] MDR_RD  = 20'h00080;
  localparam logic [19:0] IR_RD   = 20'h00100;
  localparam logic [19:0] PC_RD   = 20'h00200;
  localparam logic [19:0] Y_RD    = 20'h00400;
  localparam logic [19:0] ZLO_RD  = 20'h00800;
  localparam logic [19:0] RIN     = 20'h01000;
  localparam logic [19:0] GRA     = 20'h02000;
  localparam logic [19:0] GRB     = 20'h04000;
  localparam logic [19:0] GRC     = 20'h08000;
  localparam logic [19:0] INCPC   = 20'h10000;
  localparam logic [19:0] READ    = 20'h20000;
  localparam logic [19:0] WRITE   = 20'h40000;
  localparam logic [19:0] CON_IN  = 20'h80000;

  typedef struct {
    state_t      st;
    logic [19:0] en;
    logic [4:0]  op;
    bit          mem;
  } step_t;

  typedef struct {
    state_t      st;
    logic [19:0] en;
    logic [4:0]  op;
    logic        run;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  step_t plan_q[$];
  exp_t mon_e;
  logic [19:0] got_en;

  control_sequencer_if bus();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign got_en = {bus.CON_in, bus.Write, bus.Read, bus.IncPC, bus.Grc, bus.Grb,
                   bus.Gra, bus.Rin, bus.Zlo_rd, bus.Y_rd, bus.PC_rd, bus.IR_rd,
                   bus.MDR_rd, bus.MAR_rd, bus.BAout, bus.C_out, bus.R_out,
                   bus.Zlo_out, bus.MDR_out, bus.PC_out};

  // ---------------------------------------------------------------- monitor
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want, input state_t st);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s (expected state %s): got 0x%0h, expected 0x%0h",
               name, st.name(), got, want);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("state_view", 32'(bus.state_view), 32'(mon_e.st), mon_e.st);
        check("enables", 32'(got_en), 32'(mon_e.en), mon_e.st);
        check("op_sel", 32'(bus.op_sel), 32'(mon_e.op), mon_e.st);
        check("run", 32'(bus.run), 32'(mon_e.run), mon_e.st);
        check("read_write_exclusive", 32'((bus.Read | bus.MDR_rd) & bus.Write),
              32'd0, mon_e.st);
      end
    end
  end

  // ------------------------------------------------------- reference model
  task automatic push_exp(input state_t st, input logic [19:0] en, input logic [4:0] op);
    exp_t e;
    e.st  = st;
    e.en  = en;
    e.op  = op;
    e.run = !(st == S_RST || st == S_HALT);
    exp_q.push_back(e);
  endtask

  task automatic add(input state_t st, input logic [19:0] en, input logic [4:0] op,
                     input bit mem);
    step_t s;
    s.st = st; s.en = en; s.op = op; s.mem = mem;
    plan_q.push_back(s);
  endtask

  // Expected step sequence of one instruction, straight from the instruction table
  task automatic build_plan(input logic [4:0] op, input logic con);
    plan_q.delete();
    add(S_T0, PC_OUT | MAR_RD | INCPC | ZLO_RD, 5'd0, 1'b0);
    add(S_T1, ZLO_OUT | PC_RD | READ | MDR_RD, 5'd0, 1'b1);
    add(S_T2, MDR_OUT | IR_RD, 5'd0, 1'b0);
    case (op)
      5'b00001: begin                                    // ldi
        add(S_T3, GRB | BAOUT | R_OUT | Y_RD, 5'd0, 1'b0);
        add(S_T4, C_OUT | ZLO_RD, 5'b00011, 1'b0);
        add(S_T5, ZLO_OUT | GRA | RIN, 5'd0, 1'b0);
      end
      5'b00000, 5'b00010: begin                          // ld / st
        add(S_T3, GRB | BAOUT | R_OUT | Y_RD, 5'd0, 1'b0);
        add(S_T4, C_OUT | ZLO_RD, 5'b00011, 1'b0);
        add(S_T5, ZLO_OUT | MAR_RD, 5'd0, 1'b0);
        if (op == 5'b00000) begin
          add(S_T6, READ | MDR_RD, 5'd0, 1'b1);
          add(S_T7, MDR_OUT | GRA | RIN, 5'd0, 1'b0);
        end else begin
          add(S_T6, GRA | R_OUT | MDR_RD, 5'd0, 1'b0);
          add(S_T7, WRITE, 5'd0, 1'b1);
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000: begin
        add(S_T3, GRB | R_OUT | Y_RD, 5'd0, 1'b0);
        add(S_T4, GRC | R_OUT | ZLO_RD, op, 1'b0);
        add(S_T5, ZLO_OUT | GRA | RIN, 5'd0, 1'b0);
      end
      5'b01100, 5'b01101, 5'b01110: begin                // addi/andi/ori
        add(S_T3, GRB | R_OUT | Y_RD, 5'd0, 1'b0);
        add(S_T4, C_OUT | ZLO_RD,
            (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110, 1'b0);
        add(S_T5, ZLO_OUT | GRA | RIN, 5'd0, 1'b0);
      end
      5'b10010: begin                                    // br
        add(S_T3, GRA | R_OUT | CON_IN, 5'd0, 1'b0);
        add(S_T4, PC_OUT | Y_RD, 5'd0, 1'b0);
        add(S_T5, C_OUT | ZLO_RD, 5'b00011, 1'b0);
        add(S_T6, con ? (ZLO_OUT | PC_RD) : 20'd0, 5'd0, 1'b0);
      end
      5'b10100: add(S_T3, GRA | R_OUT | PC_RD, 5'd0, 1'b0);   // jr
      5'b11011: add(S_HALT, 20'd0, 5'd0, 1'b0);               // halt
      default: ;                                               // nop / undefined
    endcase
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic reset_recover();
    repeat (2) begin
      @(posedge clk); #1;
      push_exp(S_RST, 20'd0, 5'd0);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    push_exp(S_RST, 20'd0, 5'd0);
  endtask

  // fw >= 0 forces that many stall cycles in T6/T7; abort_at pulls clr low
  // in the first cycle of that state.
  task automatic run_instr(input logic [31:0] ir_val, input logic con, input int fw,
                           input state_t abort_at);
    build_plan(ir_val[31:27], con);
    foreach (plan_q[i]) begin
      int w;
      w = 0;
      if (plan_q[i].mem)
        w = (fw >= 0 && plan_q[i].st != S_T1) ? fw : int'($urandom_range(0, 2));
      for (int k = 0; k <= w; k++) begin
        @(posedge clk); #1;
        if (i == 0 && k == 0) begin
          bus.ir     = ir_val;
          bus.con_ff = con;
        end
        if (plan_q[i].st == abort_at) begin
          clr = 1'b0;
          push_exp(S_RST, 20'd0, 5'd0);
          reset_recover();
          return;
        end
        bus.mem_ready = plan_q[i].mem ? (k == w) : 1'($urandom_range(0, 1));
        push_exp(plan_q[i].st, plan_q[i].en, plan_q[i].op);
      end
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [26:0] low;
    low = 27'($urandom);
    return {op, low};
  endfunction

  initial begin
    logic [4:0] op;
    bus.ir        = 32'd0;
    bus.con_ff    = 1'b0;
    bus.mem_ready = 1'b1;
    clr           = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      push_exp(S_RST, 20'd0, 5'd0);
    end
    @(posedge clk); #1;
    clr = 1'b1;
    push_exp(S_RST, 20'd0, 5'd0);

    // directed: ldi R4,R2,0x54 / ld with 3 wait cycles / st / br taken+not / sub / nop
    run_instr({5'b00001, 4'd4, 4'd2, 19'h54}, 1'b0, 0, S_RST);
    run_instr(mk(OP_LD), 1'b0, 3, S_RST);
    run_instr(mk(OP_ST), 1'b0, 2, S_RST);
    run_instr(mk(OP_BR), 1'b1, 0, S_RST);
    run_instr(mk(OP_BR), 1'b0, 0, S_RST);
    run_instr(mk(OP_SUB), 1'b0, 0, S_RST);
    run_instr(mk(OP_NOP), 1'b0, 0, S_RST);
    run_instr(mk(OP_JR), 1'b0, 0, S_RST);

    // randomized instruction stream (halt saved for the end)
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_HALT) op = OP_NOP;
      run_instr(mk(op), 1'($urandom_range(0, 1)), -1, S_RST);
    end

    // reset in the middle of an instruction, then resume
    run_instr(mk(OP_LDI), 1'b0, 0, S_T4);
    run_instr(mk(OP_ADDI), 1'b0, -1, S_RST);
    run_instr(mk(OP_LD), 1'b0, -1, S_T6);
    run_instr(mk(OP_ORI), 1'b0, -1, S_RST);

    // halt: absorbing for 20 cycles, leaves only via clr
    run_instr(mk(OP_HALT), 1'b0, -1, S_RST);
    repeat (19) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'($urandom_range(0, 1));
      push_exp(S_HALT, 20'd0, 5'd0);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    push_exp(S_RST, 20'd0, 5'd0);
    reset_recover();
    run_instr(mk(OP_ANDI), 1'b0, -1, S_RST);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
